// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Shared constants and the FSM state type for the instruction fetch stage.
//   XLEN             : instruction / address width
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden by the top parameter
//   NOP_INST         : value of the decode register after reset (addi x0,x0,0)
//   fetch_state_t    : FS_FETCH / FS_WAIT / FS_KILL
package fetch_stage_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_WAIT  = 2'd1,
        FS_KILL  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage
// Owns the PC, issues single-outstanding word reads to instruction memory and
// holds each returned instruction with its PC in a one-entry register for decode.
// Redirects from execute steer the PC, flush the register and squash in-flight reads.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   imem_req_valid   : out, fetch request valid
//   imem_req_addr    : out, word-aligned fetch address
//   imem_req_ready   : in,  memory accepts the request
//   imem_rsp_valid   : in,  read data valid
//   imem_rsp_data    : in,  instruction word
//   redirect_valid   : in,  execute requests a PC change
//   redirect_pc      : in,  new PC (bits [1:0] ignored)
//   id_ready         : in,  decode consumes the output register
//   id_valid         : out, output register holds an instruction
//   id_inst, id_pc   : out, instruction and its address
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FS_FETCH | no request outstanding; request pc when the slot is free
// FS_WAIT  | one request outstanding, its response fills the slot
// FS_KILL  | one stale request outstanding, its response is discarded
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_inst,
    output logic [DATA_WIDTH-1:0] id_pc
);

    fetch_state_t          state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] req_pc;
    logic                  slot_free;
    logic                  req_fire;
    logic                  unused_redirect_lsbs;

    // The slot counts as free when decode drains it this cycle, so a request
    // can overlap the consume. Once raised, req_valid cannot drop without a
    // handshake or redirect: the slot stays free while in FS_FETCH.
    assign slot_free      = !id_valid || id_ready;
    assign imem_req_valid = !rst && (state == FS_FETCH) && slot_free;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FS_FETCH;
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            id_valid <= 1'b0;
            id_inst  <= DATA_WIDTH'(NOP_INST);
            id_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            // Redirect wins over handshake, response and consume alike.
            pc       <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            id_valid <= 1'b0;
            case (state)
                FS_FETCH: state <= req_fire ? FS_KILL : FS_FETCH;
                FS_WAIT,
                FS_KILL:  state <= imem_rsp_valid ? FS_FETCH : FS_KILL;
                default:  state <= FS_FETCH;
            endcase
        end else begin
            if (id_valid && id_ready) begin
                id_valid <= 1'b0;
            end
            case (state)
                FS_FETCH: begin
                    if (req_fire) begin
                        pc     <= pc + DATA_WIDTH'(4);
                        req_pc <= pc;
                        state  <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem_rsp_valid) begin
                        id_inst  <= imem_rsp_data;
                        id_pc    <= req_pc;
                        id_valid <= 1'b1;
                        state    <= FS_FETCH;
                    end
                end
                FS_KILL: begin
                    if (imem_rsp_valid) begin
                        state <= FS_FETCH;
                    end
                end
                default: state <= FS_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        id_ready       = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_consumed = 0;

    // Reference model: the architectural fetch stream. Each accepted,
    // non-squashed request adds the next sequential PC; redirect/reset restart it.
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] model_pc = 32'h0;

    // Stimulus knobs
    int  mem_lat_min = 1, mem_lat_max = 1;
    int  mem_rdy_pct = 100, idr_pct = 100, redir_pct = 0, rst_pmil = 0;
    int  rst_hold = 2;
    bit  force_redirect = 1'b0, redirect_on_rsp = 1'b0;
    logic [31:0] force_target = 32'h0;
    bit  seq_mode = 1'b0;
    int  last_consume = -1;

    // Behavioural memory
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;

    bit          s_hs = 1'b0, s_redirect = 1'b0;
    bit          prev_rst = 1'b0, prev_redirect = 1'b0, prev_req_pending = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit busy_at_start;
        int lat;
        @(negedge clk);
        cyc++;
        if (rst_hold > 0) begin
            rst = 1'b1; rst_hold--;
        end else if (rst_pmil > 0 && $urandom_range(999) < rst_pmil) begin
            rst = 1'b1; rst_hold = 1;
        end else begin
            rst = 1'b0;
        end
        busy_at_start  = mem_busy;
        imem_rsp_valid = 1'b0;
        if (rst) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_busy       = 1'b0;
            end
        end
        imem_req_ready = ($urandom_range(99) < mem_rdy_pct);
        id_ready       = ($urandom_range(99) < idr_pct);
        redirect_valid = 1'b0;
        if (!rst) begin
            if (force_redirect || (redirect_on_rsp && imem_rsp_valid)) begin
                redirect_valid  = 1'b1;
                redirect_pc     = force_target;
                force_redirect  = 1'b0;
                redirect_on_rsp = 1'b0;
            end else if ($urandom_range(99) < redir_pct) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
        end
        #1;
        s_hs       = 1'b0;
        s_redirect = redirect_valid;
        if (prev_rst) begin
            check("reset_id_valid", id_valid, 32'h0);
            check("reset_id_pc",    id_pc,    32'h0);
            check("reset_id_inst",  id_inst,  32'h13);
        end
        if (rst) begin
            check("req_low_in_reset", imem_req_valid, 32'h0);
            exp_q.delete();
            model_pc = 32'h0;
        end else begin
            if (prev_rst) begin
                check("first_req_valid", imem_req_valid, 32'h1);
                check("first_req_addr",  imem_req_addr,  32'h0);
            end
            if (prev_redirect) check("flush_after_redirect", id_valid, 32'h0);
            if (id_valid && !id_ready) check("no_req_while_stalled", imem_req_valid, 32'h0);
            if (busy_at_start) check("single_outstanding", imem_req_valid, 32'h0);
            if (prev_req_pending) begin
                check("req_held_valid", imem_req_valid, 32'h1);
                check("req_held_addr",  imem_req_addr,  prev_addr);
            end
            if (imem_req_valid) check("req_addr_aligned", {30'h0, imem_req_addr[1:0]}, 32'h0);
            s_hs = imem_req_valid && imem_req_ready;
            if (s_hs) begin
                lat      = int'($urandom_range(mem_lat_max, mem_lat_min));
                mem_busy = 1'b1;
                mem_addr = imem_req_addr;
                mem_cnt  = lat;
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = {redirect_pc[31:2], 2'b00};
            end else if (s_hs) begin
                check("req_addr", imem_req_addr, model_pc);
                exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc)});
                model_pc = model_pc + 32'd4;
            end
        end
        prev_rst         = rst;
        prev_redirect    = redirect_valid;
        prev_req_pending = !rst && imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr        = imem_req_addr;
    endtask

    task automatic wait_hs(input string name, input int max_cycles);
        bit got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            step();
            got = s_hs;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: no handshake within %0d cycles, expected one", name, max_cycles);
        end
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        bit got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            step();
            got = id_valid;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: id_valid not seen within %0d cycles, expected high", name, max_cycles);
        end
    endtask

    // Monitor: pops the expected stream on every consume.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && id_valid && id_ready && !redirect_valid) begin
            n_consumed++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_inst: got pc %h inst %h, expected no instruction", id_pc, id_inst);
            end else begin
                e = exp_q.pop_front();
                check("id_pc",   id_pc,   e.pc);
                check("id_inst", id_inst, e.inst);
            end
            if (seq_mode) begin
                if (last_consume >= 0) check("seq_gap", 32'(cyc - last_consume), 32'd2);
                last_consume = cyc;
            end
        end
    end

    initial begin
        logic [31:0] held_pc, held_inst;
        int          consumed_before;

        // Reset then sequential fetch with a 1-cycle memory
        repeat (2) step();
        seq_mode = 1'b1;
        last_consume = -1;
        consumed_before = n_consumed;
        repeat (20) step();
        seq_mode = 1'b0;
        check("seq_progress", 32'(n_consumed - consumed_before >= 9), 32'h1);

        // Backpressure
        idr_pct = 0;
        wait_valid("bp_fill", 10);
        held_pc   = id_pc;
        held_inst = id_inst;
        repeat (5) begin
            step();
            check("bp_valid_held", id_valid, 32'h1);
            check("bp_pc_held",    id_pc,    held_pc);
            check("bp_inst_held",  id_inst,  held_inst);
        end
        idr_pct = 100;
        step();
        check("bp_release_req", imem_req_valid, 32'h1);

        // Redirect while a 3-cycle read is outstanding
        mem_lat_min = 3; mem_lat_max = 3;
        wait_hs("rd_first_hs", 10);
        force_redirect = 1'b1;
        force_target   = 32'h0000_0043;
        step();
        begin
            bit got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                step();
                check("rd_stale_dropped", id_valid, 32'h0);
                got = s_hs;
            end
            check("rd_new_hs_seen", 32'(got), 32'h1);
        end
        check("rd_new_addr", imem_req_addr, 32'h0000_0040);
        wait_valid("rd_fill", 10);
        check("rd_id_pc", id_pc, 32'h0000_0040);

        // Redirect in the same cycle as the response
        mem_lat_min = 2; mem_lat_max = 2;
        wait_hs("rr_hs", 10);
        redirect_on_rsp = 1'b1;
        force_target    = 32'h0000_0100;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 5 && !got; i++) begin
                step();
                got = s_redirect;
            end
            check("rr_redirect_seen", 32'(got), 32'h1);
        end
        step();
        check("rr_id_valid", id_valid, 32'h0);
        check("rr_req_valid", imem_req_valid, 32'h1);
        check("rr_req_addr", imem_req_addr, 32'h0000_0100);

        // PC wrap with request hold under memory throttling
        mem_lat_min = 1; mem_lat_max = 1;
        mem_rdy_pct = 0;
        force_redirect = 1'b1;
        force_target   = 32'hFFFF_FFFC;
        step();
        begin
            bit got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                step();
                got = imem_req_valid;
            end
            check("wrap_req_seen", 32'(got), 32'h1);
        end
        repeat (3) begin
            step();
            check("wrap_hold_valid", imem_req_valid, 32'h1);
            check("wrap_hold_addr",  imem_req_addr,  32'hFFFF_FFFC);
        end
        mem_rdy_pct = 100;
        wait_hs("wrap_hs", 5);
        check("wrap_hs_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_hs("wrap_next_hs", 10);
        check("wrap_next_addr", imem_req_addr, 32'h0000_0000);

        // Randomized traffic
        mem_lat_min = 1; mem_lat_max = 4;
        mem_rdy_pct = 70; idr_pct = 70; redir_pct = 3; rst_pmil = 3;
        consumed_before = n_consumed;
        repeat (3000) step();
        check("rand_progress", 32'(n_consumed - consumed_before > 100), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
